rmii_rx_frame_writer: RTL
=========================

// Module: rmii_rx_frame_writer
// PURPOSE
//  RMII receive front end; sits directly upstream of the 2-bit dibit buffer.
//  Samples RXD/CRS_DV every i_clock (50 MHz REF_CLK, 100 Mb/s, one dibit per clock).
//  Strips preamble/SFD, writes payload dibits to the buffer with sequential addresses,
//  and reports each frame to the consumer via a ready/ack handshake.
// PARAMETERS
//  DEPTH      288  buffer capacity in dibits; max frame payload kept
//  ADDR_W     9    address width of buffer write port
//  MIN_DIBITS 4    shortest legal payload (dibits); shorter => error
// PORTS
//  i_clock        in   1       REF_CLK; all logic on rising edge
//  i_reset        in   1       synchronous, active-high reset
//  i_rxd          in   2       RMII RXD[1:0]
//  i_crs_dv       in   1       RMII CRS_DV (carrier + data valid, assumed already de-toggled)
//  i_rx_er        in   1       RMII RX_ER
//  i_frame_ack    in   1       consumer done with buffered frame; 1-cycle pulse
//  o_data_out     out  2       dibit to buffer write data
//  o_addr_write   out  ADDR_W  buffer write address
//  o_enab_write   out  1       buffer write enable
//  o_frame_ready  out  1       complete frame in buffer, held until ack
//  o_frame_len    out  ADDR_W  payload length in dibits, valid while o_frame_ready
//  o_frame_err    out  1       frame flags (RX_ER/overflow/misalign/runt), valid with ready
//  o_drop         out  1       1-cycle pulse: frame discarded because buffer still owned
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; address counter 0; sticky error 0.
//  All outputs registered: dibit sampled cycle n appears on o_data_out/o_enab_write at n+1.
//  States:
//   IDLE:  crs_dv=1 & rxd=2'b01 -> PREAMBLE; crs_dv=1 & o_frame_ready=1 -> DISCARD (pulse o_drop).
//   PREAMBLE: rxd=01 stay; rxd=11 (SFD last dibit) -> DATA, addr<=0; other value -> DISCARD;
//     crs_dv=0 -> IDLE (no report).
//   DATA: crs_dv=1: write rxd at addr, addr++; rx_er=1 sets sticky err.
//     addr==DEPTH-1 written -> next valid dibit sets err (overflow), no write, -> DISCARD.
//     crs_dv=0: no write; -> DONE.
//   DONE (1 cycle): o_frame_len<=addr; err|=(addr[1:0]!=0)|(addr<MIN_DIBITS);
//     o_frame_ready<=1; -> IDLE.
//   DISCARD: no writes; wait crs_dv=0 -> IDLE. Overflow path goes via DONE instead
//     (report len=DEPTH, err=1) when crs_dv falls.
//  Handshake: o_frame_ready rises 1 cycle after DONE, holds until i_frame_ack sampled,
//   clears next cycle; ack while not ready ignored. Ack and new carrier same cycle:
//   ack wins first, frame accepted (not dropped).
//  Frame arriving while ready=1: whole frame discarded, buffer untouched, o_drop pulses once.
//  Address never wraps: writes only at 0..DEPTH-1.
//  i_reset mid-frame: abort immediately, no report, ready cleared; next frame needs fresh preamble.
//  Length arithmetic: ADDR_W bits, DEPTH <= 2^ADDR_W enforced by elaboration check.
// STRUCTURE
//  Shared package: state encoding (IDLE, PREAMBLE, DATA, DONE, DISCARD), RMII constants
//   PREAMBLE_DIBIT=2'b01, SFD_DIBIT=2'b11, default DEPTH/ADDR_W.
//  One sub-module natural: rmii_rx_err_tracker (sticky RX_ER/overflow/misalign/runt flags).
//  FSM, address counter, handshake register in top.
// TESTING
//  1 7x01 + 11 + 64 payload dibits, crs_dv drop -> 64 writes addr 0..63, ready=1, len=64, err=0.
//  2 Same frame, rx_er=1 on dibit 10 -> all 64 written, len=64, err=1.
//  3 300-dibit payload -> writes addr 0..287 only, len=288, err=1.
//  4 Frame 2 sent before ack of frame 1 -> no writes, o_drop one pulse, len stays 64;
//    ack then frame 3 -> accepted.
//  5 Payload of 2 dibits (runt) and of 65 dibits (misaligned) -> ready=1, err=1 each.
//  6 Reset asserted at payload dibit 20 -> outputs 0 next cycle, no ready;
//    clean frame afterwards -> len correct.

Source files
------------

// File: rtl/rmii_rx_frame_writer_pkg.sv
// Shared types and constants for the RMII receive frame writer.
// State encoding, RMII dibit codes and default buffer geometry.
package rmii_rx_frame_writer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DONE,
        S_DISCARD
    } state_e;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT      = 2'b11;

    localparam int DEF_DEPTH      = 288;
    localparam int DEF_ADDR_W     = 9;
    localparam int DEF_MIN_DIBITS = 4;

endpackage

// File: rtl/rmii_rx_frame_writer_if.sv
// Buffer write port plus frame-report handshake.
// master = frame writer, slave = buffer/consumer side.
interface rmii_rx_frame_writer_if
    import rmii_rx_frame_writer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [1:0]        o_data_out;
    logic [ADDR_W-1:0] o_addr_write;
    logic              o_enab_write;
    logic              o_frame_ready;
    logic [ADDR_W-1:0] o_frame_len;
    logic              o_frame_err;
    logic              o_drop;
    logic              i_frame_ack;

    modport master (
        output o_data_out, o_addr_write, o_enab_write,
        output o_frame_ready, o_frame_len, o_frame_err, o_drop,
        input  i_frame_ack
    );

    modport slave (
        input  o_data_out, o_addr_write, o_enab_write,
        input  o_frame_ready, o_frame_len, o_frame_err, o_drop,
        output i_frame_ack
    );
endinterface

// File: rtl/rmii_rx_err_tracker.sv
// Sticky per-frame error flags for the frame writer.
// Cleared while idle; final flag folds in misalign and runt checks.
module rmii_rx_err_tracker
    import rmii_rx_frame_writer_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int MIN_DIBITS = DEF_MIN_DIBITS
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            er_hit_i,
    input  logic            ovf_hit_i,
    input  logic [ADDR_W:0] cnt_i,
    output logic            ovf_o,
    output logic            err_o
);
    localparam logic [ADDR_W:0] MIN_C = (ADDR_W+1)'(MIN_DIBITS);

    logic sticky_q, sticky_d;
    logic ovf_q, ovf_d;

    // Flag registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
        end
    end

    // Accumulate hits, clear between frames
    always_comb begin
        sticky_d = sticky_q | er_hit_i | ovf_hit_i;
        ovf_d    = ovf_q | ovf_hit_i;
        if (clr_i) begin
            sticky_d = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    assign ovf_o = ovf_q;
    assign err_o = sticky_q
                 | (cnt_i[1:0] != 2'b00)
                 | (cnt_i < MIN_C);
endmodule

// File: rtl/rmii_rx_frame_writer.sv
// RMII receive front end: strips preamble/SFD, writes payload
// dibits to the buffer and reports each frame via ready/ack.
module rmii_rx_frame_writer
    import rmii_rx_frame_writer_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int MIN_DIBITS = DEF_MIN_DIBITS
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [1:0] i_rxd,
    input  logic       i_crs_dv,
    input  logic       i_rx_er,
    rmii_rx_frame_writer_if.master bus
);
    if (DEPTH > (2 ** ADDR_W)) begin : g_depth_chk
        $error("DEPTH does not fit in ADDR_W");
    end

    // Counter is one bit wider so a full buffer reads as DEPTH
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [1:0]        data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              err_q, err_d;
    logic              drop_q, drop_d;
    logic              er_hit, ovf_hit;
    logic              ovf, err_final, busy;

    rmii_rx_err_tracker #(
        .ADDR_W    (ADDR_W),
        .MIN_DIBITS(MIN_DIBITS)
    ) u_err (
        .clk_i    (i_clock),
        .rst_i    (i_reset),
        .clr_i    (state_q == S_IDLE),
        .er_hit_i (er_hit),
        .ovf_hit_i(ovf_hit),
        .cnt_i    (cnt_q),
        .ovf_o    (ovf),
        .err_o    (err_final)
    );

    // State and output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            len_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            len_q   <= len_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state, buffer writes and frame report
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        ready_d = ready_q & ~bus.i_frame_ack;
        len_d   = len_q;
        err_d   = err_q;
        drop_d  = 1'b0;
        er_hit  = 1'b0;
        ovf_hit = 1'b0;
        // An ack in the same cycle frees the buffer for this carrier
        busy    = ready_q & ~bus.i_frame_ack;
        unique case (state_q)
            S_IDLE: begin
                if (i_crs_dv) begin
                    if (busy) begin
                        state_d = S_DISCARD;
                        drop_d  = 1'b1;
                    end else if (i_rxd == PREAMBLE_DIBIT) begin
                        state_d = S_PREAMBLE;
                    end
                end
            end
            S_PREAMBLE: begin
                if (!i_crs_dv) begin
                    state_d = S_IDLE;
                end else if (i_rxd == SFD_DIBIT) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else if (i_rxd != PREAMBLE_DIBIT) begin
                    state_d = S_DISCARD;
                end
            end
            S_DATA: begin
                if (!i_crs_dv) begin
                    state_d = S_DONE;
                end else if (cnt_q == DEPTH_C) begin
                    ovf_hit = 1'b1;
                    state_d = S_DISCARD;
                end else begin
                    we_d   = 1'b1;
                    data_d = i_rxd;
                    addr_d = cnt_q[ADDR_W-1:0];
                    cnt_d  = cnt_q + ONE_C;
                    er_hit = i_rx_er;
                end
            end
            S_DONE: begin
                len_d   = cnt_q[ADDR_W-1:0];
                err_d   = err_final;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            S_DISCARD: begin
                if (!i_crs_dv) begin
                    state_d = ovf ? S_DONE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_data_out    = data_q;
    assign bus.o_addr_write  = addr_q;
    assign bus.o_enab_write  = we_q;
    assign bus.o_frame_ready = ready_q;
    assign bus.o_frame_len   = len_q;
    assign bus.o_frame_err   = err_q;
    assign bus.o_drop        = drop_q;
endmodule
